dual_issue_instr_queue: RTL
===========================

Name: dual_issue_instr_queue

Overview:
- Parametrised two-wide instruction queue between fetch and the dual-issue decode stage of the SPU.
- Accepts 0, 1 or 2 instructions per cycle from fetch, each tagged with its PC.
- Presents the two oldest entries to decode, which retires 0, 1 or 2 per cycle depending on even/odd pairing.
- A taken branch from the odd pipe flushes the whole queue in one cycle.

Parameters:
- DEPTH, 8: number of entries; power of two, at least 4.
- INSTR_W, 32: instruction width in bits.
- PC_W, 32: program-counter width in bits.
- NOP_ENC, 32'h40200000: encoding driven on any head slot that holds no valid instruction.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- push_cnt  in  2  number of instructions offered this cycle (0..2); value 3 is treated as 0
- push_instr0  in  INSTR_W  older offered instruction
- push_instr1  in  INSTR_W  younger offered instruction
- push_pc  in  PC_W  PC of push_instr0; push_instr1 implicitly has push_pc+4
- space  out  2  min(free entries, 2), computed from registered state
- pop_cnt  in  2  instructions retired by decode this cycle (0..2); value 3 is treated as 2
- head_valid  out  2  bit0 = entry 0 valid, bit1 = entry 1 valid
- head_instr0  out  INSTR_W  oldest instruction, or NOP_ENC when invalid
- head_instr1  out  INSTR_W  second-oldest instruction, or NOP_ENC when invalid
- head_pc0  out  PC_W  PC of oldest entry, 0 when invalid
- head_pc1  out  PC_W  PC of second entry, 0 when invalid
- flush  in  1  branch_taken from the odd pipe
- count  out  $clog2(DEPTH)+1  current occupancy

Behaviour:
- Storage: circular buffer of DEPTH entries; each entry holds {instr, pc}. Read pointer rd_ptr, write pointer wr_ptr, occupancy count.
- Reset, and flush while reset is low, both force: rd_ptr=0, wr_ptr=0, count=0. Resulting outputs: space=2, head_valid=0, head_instr0/1=NOP_ENC, head_pc0/1=0. Entry contents need not be cleared.
- Reset takes priority over flush, push and pop. Reset asserted mid-stream discards every entry on the next edge.
- Head outputs are combinational from registered state; no added latency.
- An instruction pushed at edge N is visible on the head outputs after edge N.
- Push rule (all-or-nothing):
  - accepted only if push_cnt <= free, where free = DEPTH - count at the start of the cycle;
  - otherwise the whole push is dropped and state is unchanged for the push side;
  - fetch must only offer push_cnt <= space, so a dropped push is a fetch protocol error;
  - an accepted push writes instr0 at wr_ptr and instr1 at wr_ptr+1 (with pc+4);
  - wr_ptr advances by push_cnt modulo DEPTH.
- Pop rule:
  - effective pops = min(pop_cnt, count); over-request is clamped silently;
  - rd_ptr advances by the effective pops modulo DEPTH.
- Simultaneous push and pop:
  - both are applied on the same edge;
  - next count = count + accepted push - effective pops;
  - push acceptance uses pre-pop free space, so same-cycle pop space is not credited.
- Flush:
  - takes priority over push and pop in the same cycle;
  - same-cycle pushed instructions are discarded (they belong to the wrong path);
  - the next cycle's push is accepted normally with space=2.
- Wrap-around: pointer arithmetic is modulo DEPTH. A two-wide push or pop may straddle the DEPTH-1 to 0 boundary.
- Full: count=DEPTH gives space=0. DEPTH-1 entries gives space=1.
- Empty: count=0 gives head_valid=00. count=1 gives head_valid=01 and head_instr1=NOP_ENC.
- PC arithmetic is modulo 2^PC_W; push_pc+4 wraps silently.
- count never exceeds DEPTH and never goes negative.

Test Plan:
1. Reset, then push_cnt=2, instr0=0x11111111, instr1=0x22222222, push_pc=0x100 -> after edge: count=2, head_valid=11, head_pc0=0x100, head_pc1=0x104, space=2.
2. Fill to DEPTH=8 with two-wide pushes, then push_cnt=1 -> dropped, count stays 8, space=0. Then pop_cnt=2 with push_cnt=2 in the same cycle -> push dropped (pre-pop space is 0), count=6.
3. Wrap: push 7 entries, pop 6, then push_cnt=2 at wr_ptr=7 -> entries land in slots 7 and 0; subsequent pops return them in order with PCs +4 apart.
4. Starting at count=1, pop_cnt=2 -> clamped, count=0, head_valid=00, head_instr0=0x40200000.
5. Starting at count=5, flush=1 with push_cnt=2 in the same cycle -> count=0, pushed pair discarded. Next cycle push_cnt=1, pc=0x200 -> head_pc0=0x200.
6. Starting at count=4, assert reset mid-stream with pop_cnt=1 and push_cnt=2 -> count=0, space=2, all head outputs at their reset values.

Source files
------------

// File: rtl/dual_issue_instr_queue_if.sv
`default_nettype none
// ============================================================================
// Module   : dual_issue_instr_queue_if
// Brief    : Fetch/decode-side bundle of the two-wide instruction queue.
// Revision : 1.0
// ============================================================================
interface dual_issue_instr_queue_if #(
    parameter int INSTR_W = 32,
    parameter int PC_W    = 32,
    parameter int CNT_W   = 4
);
    logic [1:0]         push_cnt;
    logic [INSTR_W-1:0] push_instr0;
    logic [INSTR_W-1:0] push_instr1;
    logic [PC_W-1:0]    push_pc;
    logic [1:0]         space;
    logic [1:0]         pop_cnt;
    logic [1:0]         head_valid;
    logic [INSTR_W-1:0] head_instr0;
    logic [INSTR_W-1:0] head_instr1;
    logic [PC_W-1:0]    head_pc0;
    logic [PC_W-1:0]    head_pc1;
    logic               flush;
    logic [CNT_W-1:0]   count;

    modport master (
        output push_cnt, push_instr0, push_instr1, push_pc, pop_cnt, flush,
        input  space, head_valid, head_instr0, head_instr1, head_pc0, head_pc1, count
    );

    modport slave (
        input  push_cnt, push_instr0, push_instr1, push_pc, pop_cnt, flush,
        output space, head_valid, head_instr0, head_instr1, head_pc0, head_pc1, count
    );
endinterface
`default_nettype wire

// File: rtl/dual_issue_instr_queue.sv
`default_nettype none
// ============================================================================
// Module   : dual_issue_instr_queue
// Brief    : Two-wide circular instruction queue between fetch and decode.
// Revision : 1.0
// ============================================================================
module dual_issue_instr_queue #(
    parameter int                 DEPTH   = 8,
    parameter int                 INSTR_W = 32,
    parameter int                 PC_W    = 32,
    parameter logic [INSTR_W-1:0] NOP_ENC = 32'h40200000
) (
    input  wire logic               clk,
    input  wire logic               reset,
    dual_issue_instr_queue_if.slave bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam logic [CNT_W-1:0] c_depth = CNT_W'(DEPTH);

    logic [INSTR_W-1:0] r_instr [DEPTH];
    logic [PC_W-1:0]    r_pc    [DEPTH];
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [PTR_W-1:0]   r_wr_ptr;
    logic [CNT_W-1:0]   r_count;

    logic [1:0]       w_push_req;
    logic [1:0]       w_push_acc;
    logic [1:0]       w_pop_req;
    logic [1:0]       w_pop_eff;
    logic [CNT_W-1:0] w_free;
    logic [PTR_W-1:0] w_wr_ptr1;
    logic [PTR_W-1:0] w_rd_ptr1;

    assign w_wr_ptr1 = r_wr_ptr + PTR_W'(1);
    assign w_rd_ptr1 = r_rd_ptr + PTR_W'(1);
    assign w_free    = c_depth - r_count;

    always_comb begin
        w_push_req = (bus.push_cnt == 2'd3) ? 2'd0 : bus.push_cnt;
        w_pop_req  = (bus.pop_cnt == 2'd3) ? 2'd2 : bus.pop_cnt;
        // All-or-nothing acceptance against pre-pop free space
        w_push_acc = (CNT_W'(w_push_req) <= w_free) ? w_push_req : 2'd0;
        w_pop_eff  = (CNT_W'(w_pop_req) <= r_count) ? w_pop_req : r_count[1:0];
    end

    always_ff @(posedge clk) begin
        if (reset || bus.flush) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            r_rd_ptr <= r_rd_ptr + PTR_W'(w_pop_eff);
            r_wr_ptr <= r_wr_ptr + PTR_W'(w_push_acc);
            r_count  <= r_count + CNT_W'(w_push_acc) - CNT_W'(w_pop_eff);
        end
    end

    // Entry storage is not reset; validity is tracked solely by r_count
    always_ff @(posedge clk) begin
        if (!reset && !bus.flush) begin
            if (w_push_acc != 2'd0) begin
                r_instr[r_wr_ptr] <= bus.push_instr0;
                r_pc[r_wr_ptr]    <= bus.push_pc;
            end
            if (w_push_acc == 2'd2) begin
                r_instr[w_wr_ptr1] <= bus.push_instr1;
                r_pc[w_wr_ptr1]    <= bus.push_pc + PC_W'(4);
            end
        end
    end

    always_comb begin
        bus.head_valid[0] = (r_count >= CNT_W'(1));
        bus.head_valid[1] = (r_count >= CNT_W'(2));
        bus.head_instr0   = bus.head_valid[0] ? r_instr[r_rd_ptr]  : NOP_ENC;
        bus.head_pc0      = bus.head_valid[0] ? r_pc[r_rd_ptr]     : '0;
        bus.head_instr1   = bus.head_valid[1] ? r_instr[w_rd_ptr1] : NOP_ENC;
        bus.head_pc1      = bus.head_valid[1] ? r_pc[w_rd_ptr1]    : '0;
        bus.space         = (w_free >= CNT_W'(2)) ? 2'd2 : w_free[1:0];
        bus.count         = r_count;
    end
endmodule
`default_nettype wire
